// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a valid/ready request side and a valid/ready result side.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    // Handshakes: a request transfers on an edge with in_valid & in_ready & !flush;
    // a result transfers on an edge with out_valid & out_ready & !flush. Once raised,
    // out_valid and result hold until that transfer, a flush or reset.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   res_q;

    logic              accept, step, finish;

    logic              a_signed, b_signed, neg_a, neg_b, start_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, step_next, signed_full;
    logic [XLEN-1:0]   quo_rem, final_res;

    // Request decode: operand magnitudes, result sign, and the one-cycle special cases.
    always_comb begin
        a_signed  = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                    (funct3 == 3'd4) || (funct3 == 3'd6);
        b_signed  = (funct3 == 3'd0) || (funct3 == 3'd1) ||
                    (funct3 == 3'd4) || (funct3 == 3'd6);
        neg_a     = a_signed & rs1[XLEN-1];
        neg_b     = b_signed & rs2[XLEN-1];
        mag_a     = neg_a ? -rs1 : rs1;
        mag_b     = neg_b ? -rs2 : rs2;
        // Remainder follows the dividend; everything else follows the operand XOR.
        start_neg = (funct3[2] && funct3[1]) ? neg_a : (neg_a ^ neg_b);
        div_zero  = funct3[2] && (rs2 == '0);
        div_ovf   = funct3[2] && !funct3[0] && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);
        special   = div_zero || div_ovf;
        if (div_zero) begin
            special_res = funct3[1] ? rs1 : ALL_ONES;
        end else begin
            special_res = funct3[1] ? '0 : MOST_NEG;
        end
    end

    // One iteration. acc holds {partial, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
        step_next   = op[2] ? div_next : mul_next;
        signed_full = neg ? -step_next : step_next;
        quo_rem     = op[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
        if (op[2]) begin
            final_res = neg ? -quo_rem : quo_rem;
        end else if (op[1:0] == 2'd0) begin
            final_res = signed_full[XLEN-1:0];
        end else begin
            final_res = signed_full[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt == LAST_STEP) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            step       = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            op    <= '0;
            neg   <= 1'b0;
            opb   <= '0;
            acc   <= '0;
            res_q <= '0;
        end else if (accept) begin
            cnt <= '0;
            op  <= funct3;
            neg <= start_neg;
            // Multiply shifts the multiplier (rs2) out of the low half; divide shifts the dividend.
            if (funct3[2]) begin
                opb <= mag_b;
                acc <= {{XLEN{1'b0}}, mag_a};
            end else begin
                opb <= mag_a;
                acc <= {{XLEN{1'b0}}, mag_b};
            end
            if (special) begin
                res_q <= special_res;
            end
        end else if (step) begin
            acc <= step_next;
            cnt <= cnt + CW'(1);
            if (finish) begin
                res_q <= final_res;
            end
        end
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign result    = out_valid ? res_q : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table, hand-written
// handshake/flush/reset sequences, and random operations against an arithmetic model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1, rs2, result;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic signed [31:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (f != 3'd3 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb  = (f <= 3'd1 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p   = ea * eb;
        case (f)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request and wait (bounded) for out_valid; lat counts the accept edge as 1.
    task automatic start_wait(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                              output int lat);
        @(negedge clk);
        funct3   = f;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] res, output int lat);
        start_wait(f, a, b, lat);
        res = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("back_to_idle", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen;

        vecs[0]  = '{3'd0, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        vecs[12] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
        vecs[13] = '{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[14] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct3 = 3'd0; rs1 = '0; rs2 = '0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Stall in DONE for 10 cycles with a second request waiting on in_valid.
        start_wait(3'd5, 32'd100, 32'd7, lat);
        check("stall_latency", lat, 33);
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_result", result, 14);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release_in_ready", in_ready, 1);
        check("stall_release_valid", out_valid, 0);
        check("stall_release_result", result, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("held_req_accepted", dbg_state, 1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_req_latency", lat, 33);
        check("held_req_result", result, 15);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Flush at BUSY cycle 10.
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'h12345; rs2 = 32'h777; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_state", dbg_state, 0);
        check("flush_busy_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_busy_no_valid", seen, 0);
        run_op(3'd0, 32'h12345, 32'h777, 0, res, lat);
        check("after_flush_result", res, ref_res(3'd0, 32'h12345, 32'h777));
        check("after_flush_latency", lat, 33);

        // Flush with in_valid in IDLE: no accept.
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_state", dbg_state, 0);
        check("flush_idle_in_ready", in_ready, 1);

        // Flush in DONE overrides out_ready and discards the result.
        start_wait(3'd7, 32'd9, 32'd4, lat);
        check("flush_done_pre_valid", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_valid", out_valid, 0);
        check("flush_done_result", result, 0);
        check("flush_done_in_ready", in_ready, 1);

        // Asynchronous reset mid-BUSY.
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_state", dbg_state, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("async_rst_no_valid", seen, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("async_rel_in_ready", in_ready, 1);
        run_op(3'd0, 32'd3, 32'd4, 0, res, lat);
        check("after_rst_mul", res, 12);
        check("after_rst_latency", lat, 33);

        // Asynchronous reset while holding a result in DONE.
        start_wait(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
        #2;
        reset = 1'b1;
        #1;
        check("rst_done_valid", out_valid, 0);
        check("rst_done_result", result, 0);
        @(negedge clk);
        reset = 1'b0;

        // Random operations with random result back-pressure.
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            exp_q.push_back(ref_res(f, a, b));
            run_op(f, a, b, $urandom_range(0, 2), res, lat);
            check($sformatf("rand%0d_f%0d_result", i, f), res, exp_q.pop_front());
            check($sformatf("rand%0d_f%0d_latency", i, f), lat, ref_lat(f, a, b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving operand and result width; legal values are 8..64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit, a synchronous abort of any in-flight operation.
REQ-005 The block SHALL have port in_valid, input, 1 bit, marking a request as present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, marking the unit as able to accept a request.
REQ-007 The block SHALL have port funct3, input, 3 bits, the operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 The block SHALL have ports rs1 and rs2, input, XLEN bits each; rs1 is the multiplicand or dividend, rs2 the multiplier or divisor.
REQ-009 The block SHALL have port out_valid, output, 1 bit, marking result as valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, marking the consumer as taking the result.
REQ-011 The block SHALL have port result, output, XLEN bits, carrying the operation result.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE with reset low, and out_valid SHALL be 1 only in DONE.
REQ-013 Accept SHALL be the rising edge where in_valid=1, in_ready=1 and flush=0; at accept the block latches funct3, the operand magnitudes and the result sign, clears the step counter, and enters BUSY.
REQ-014 Signedness SHALL be per op: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-015 Multiply SHALL be iterative shift-add, consuming 1 multiplier bit per cycle over XLEN BUSY cycles into a 2*XLEN-bit product; MUL returns the low XLEN bits and MULH/MULHSU/MULHU return the high XLEN bits of the correctly signed product.
REQ-016 Divide SHALL be restoring, producing 1 quotient bit per cycle over XLEN BUSY cycles; quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1); quotient truncates toward zero.
REQ-017 Final negation SHALL be applied on the BUSY-to-DONE transition so that result is constant throughout DONE.
REQ-018 Normal latency SHALL be exactly XLEN+1 rising edges from accept to the first edge at which out_valid=1.
REQ-019 For divisor zero, the block SHALL go directly to DONE on the accept edge (latency 1): DIV/DIVU return all ones; REM/REMU return rs1.
REQ-020 For DIV/REM with rs1 = most-negative and rs2 = all ones, the block SHALL go directly to DONE (latency 1): DIV returns most-negative; REM returns 0.
REQ-021 The block SHALL hold DONE, result and out_valid stable while out_ready=0, with no timeout.
REQ-022 An edge with out_valid=1 and out_ready=1 SHALL move the FSM to IDLE; since in_ready=0 in DONE, there is no same-cycle re-accept, giving a minimum issue interval of latency+1 cycles.
REQ-023 flush=1 at an edge SHALL force IDLE from any state, discarding any pending result; flush overrides in_valid and out_ready in the same cycle.
REQ-024 result SHALL read 0 whenever out_valid=0.
REQ-025 The step counter SHALL be $clog2(XLEN)+1 bits wide and SHALL end BUSY when it reaches XLEN-1 at an edge.

Reset
REQ-026 While reset=1, the block SHALL immediately force state=IDLE, out_valid=0, in_ready=0, result=0, counter=0 and all datapath registers to 0.
REQ-027 On the first edge after reset falls, in_ready SHALL read 1; reset asserted mid-BUSY or mid-DONE SHALL abandon the operation with no out_valid pulse.

Verification (XLEN=32)
REQ-028 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB with out_valid exactly 33 edges after accept; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-029 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with out_valid 1 edge after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each 1 edge after accept.
REQ-031 Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable; then out_ready=1 -> IDLE next edge and in_ready=1; a request held on in_valid the whole time is accepted only then.
REQ-032 flush at BUSY cycle 10 -> IDLE next edge with no out_valid; the next request then completes correctly; flush together with in_valid in IDLE -> not accepted.
REQ-033 Assert reset asynchronously mid-BUSY between edges -> out_valid=0 and in_ready=0 immediately; after release, a fresh MUL 3*4 returns 12.
